sonar_frame_capture: RTL and testbench

Capture sequencer sitting directly upstream of the 6-bit enabled address counter in the sonar receive path. It arms on a start pulse, waits for the ADC stream to cross a threshold, then paces 64 sample writes at a divided rate, stepping the counter through count_enable and using its output as the buffer write address. It also tracks the frame peak and hands a completed frame to the readout logic through a done/ack handshake.

---
 rtl/sonar_frame_capture.sv | 123 ++++++++++++
 tb/tb_sonar_frame_capture.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_frame_capture.sv
// Capture sequencer for the sonar receive path: arms on start, triggers on a threshold
// crossing, paces 64 buffer writes through the external address counter and tracks the frame peak.
module sonar_frame_capture #(
    parameter int DATA_WIDTH = 12,
    parameter int DIV        = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] threshold,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic [5:0]            count_q,
    output logic                  count_enable,
    output logic                  wr_en,
    output logic [5:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  frame_done,
    input  logic                  frame_ack,
    output logic [DATA_WIDTH-1:0] peak_value,
    output logic [5:0]            peak_index,
    output logic                  seq_error
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        FLUSH,
        DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [5:0] idx;
    logic       tick;
    logic       flush_step;

    assign tick         = (state == CAPTURE) && (div_cnt == DIV_LAST);
    // A flush entered with the counter already at 0 must not step it off zero.
    assign flush_step   = (state == FLUSH) && (count_q != 6'd0);
    assign count_enable = tick || flush_step;
    assign busy         = (state != IDLE);
    assign frame_done   = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            idx        <= 6'd0;
            wr_en      <= 1'b0;
            wr_addr    <= 6'd0;
            wr_data    <= '0;
            peak_value <= '0;
            peak_index <= 6'd0;
            seq_error  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ARMED;
                        seq_error <= (count_q != 6'd0);
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (adc_data >= threshold) begin
                        state      <= CAPTURE;
                        div_cnt    <= 8'd0;
                        idx        <= 6'd0;
                        peak_value <= '0;
                        peak_index <= 6'd0;
                    end
                end
                CAPTURE: begin
                    if (tick) begin
                        div_cnt <= 8'd0;
                        wr_en   <= 1'b1;
                        wr_addr <= count_q;
                        wr_data <= adc_data;
                        idx     <= idx + 6'd1;
                        // Strict compare so ties keep the earliest address.
                        if (adc_data > peak_value) begin
                            peak_value <= adc_data;
                            peak_index <= count_q;
                        end
                        if (count_q != idx) begin
                            seq_error <= 1'b1;
                        end
                        if (abort) begin
                            state <= FLUSH;
                        end else if (idx == 6'd63) begin
                            state <= DONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                        if (abort) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if ((count_q == 6'd0) || (count_q == 6'd63)) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (frame_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_frame_capture.sv
// Self-checking bench for sonar_frame_capture: cycle table for arming, randomized frames
// checked against a sample-slot model, plus reset, abort, sequencing-error and handshake corners.
module tb_sonar_frame_capture;

    localparam int DW  = 12;
    localparam int DIV = 4;
    localparam int NC  = 64 * DIV;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          frame_ack = 1'b0;
    logic [DW-1:0] threshold = '0;
    logic [DW-1:0] adc_data = '0;
    logic          force_cq = 1'b0;
    logic [5:0]    cnt;
    logic [5:0]    count_q;
    logic          count_enable, wr_en, busy, frame_done, seq_error;
    logic [5:0]    wr_addr, peak_index;
    logic [DW-1:0] wr_data, peak_value;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          start;
        logic          abort;
        logic [DW-1:0] adc;
        logic          exp_busy;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    // Address counter the sequencer drives; can be overridden to model a decoupled counter.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= 6'd0;
        else if (count_enable) cnt <= cnt + 6'd1;
    end
    assign count_q = force_cq ? 6'd5 : cnt;

    sonar_frame_capture #(.DATA_WIDTH(DW), .DIV(DIV)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .abort        (abort),
        .threshold    (threshold),
        .adc_data     (adc_data),
        .count_q      (count_q),
        .count_enable (count_enable),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_ack    (frame_ack),
        .peak_value   (peak_value),
        .peak_index   (peak_index),
        .seq_error    (seq_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame from start to DONE (or through FLUSH when abort_at < 64).
    task automatic run_frame(input logic [DW-1:0] thr, input int pre, input int mode,
                             input int abort_at, input bit poke_start, input bit force_at_start);
        logic [DW-1:0] d [NC];
        logic [DW-1:0] pk;
        logic [5:0]    pki;
        int ncyc, en_cnt, wr_cnt, fd_cnt, k;
        for (int c = 0; c < NC; c++) begin
            int n = c / DIV;
            case (mode)
                0:       d[c] = DW'($urandom_range(0, 4095));
                1:       d[c] = DW'($urandom_range(0, 3));
                default: d[c] = (n == 10 || n == 40) ? 12'h7FF : 12'h010;
            endcase
        end
        // Sample n is whatever the ADC shows in the last cycle of its DIV-cycle slot.
        pk  = '0;
        pki = 6'd0;
        for (int n = 0; n < 64; n++) begin
            if (d[n*DIV + DIV - 1] > pk) begin
                pk  = d[n*DIV + DIV - 1];
                pki = 6'(n);
            end
        end

        threshold = thr;
        adc_data  = '0;
        start     = 1'b1;
        force_cq  = force_at_start;
        step();
        start    = 1'b0;
        force_cq = 1'b0;
        check("arm_busy", busy, 1);
        check("arm_seq_error", seq_error, 32'(force_at_start));

        for (int i = 0; i < pre; i++) begin
            adc_data = DW'((i * int'(thr)) / pre);
            step();
            check("armed_wait", busy, 1);
            check("armed_no_write", wr_en, 0);
        end
        adc_data = (thr <= 12'd4075) ? thr + 12'd20 : thr;
        step();

        ncyc = (abort_at < 64) ? abort_at * DIV + 1 : NC;
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0 && ((c - 1) % DIV) == DIV - 1) begin
                check("tick_wr_en", wr_en, 1);
                check("wr_addr", wr_addr, 32'((c - 1) / DIV));
                check("wr_data", wr_data, d[c-1]);
            end else begin
                check("gap_wr_en", wr_en, 0);
            end
            if (c < ncyc) begin
                check("count_enable", count_enable, 32'((c % DIV) == DIV - 1));
                check("capture_done_low", frame_done, 0);
                abort    = (abort_at < 64) && (c == ncyc - 1);
                start    = poke_start && (c == 37);
                adc_data = d[c];
                step();
            end
        end
        abort = 1'b0;
        start = 1'b0;

        if (abort_at < 64) begin
            en_cnt = 0; wr_cnt = 0; fd_cnt = 0; k = 0;
            while (busy && k < 200) begin
                if (count_enable) en_cnt++;
                if (wr_en) wr_cnt++;
                if (frame_done) fd_cnt++;
                step();
                k++;
            end
            check("flush_enables", en_cnt, 32'(64 - abort_at));
            check("flush_writes", wr_cnt, 0);
            check("flush_no_done", fd_cnt, 0);
            check("flush_to_idle", busy, 0);
            check("flush_count_q", count_q, 0);
        end else begin
            check("frame_done", frame_done, 1);
            check("end_count_q", count_q, 0);
            check("peak_value", peak_value, pk);
            check("peak_index", peak_index, pki);
            check("end_seq_error", seq_error, 32'(force_at_start));
        end
    endtask

    task automatic finish_frame(input bit ack_with_start);
        start = 1'b1;
        step();
        start = 1'b0;
        check("done_ignores_start", frame_done, 1);
        check("done_no_write", wr_en, 0);
        frame_ack = 1'b1;
        start     = ack_with_start;
        step();
        frame_ack = 1'b0;
        start     = 1'b0;
        check("ack_clears_done", frame_done, 0);
        check("ack_to_idle", busy, 0);
        adc_data = 12'hFFF;
        step();
        check("stays_idle", busy, 0);
    endtask

    initial begin
        vecs[0] = '{start: 1'b0, abort: 1'b0, adc: 12'd0,   exp_busy: 1'b0};
        vecs[1] = '{start: 1'b1, abort: 1'b0, adc: 12'd0,   exp_busy: 1'b1};
        vecs[2] = '{start: 1'b0, abort: 1'b0, adc: 12'd50,  exp_busy: 1'b1};
        vecs[3] = '{start: 1'b0, abort: 1'b1, adc: 12'd200, exp_busy: 1'b0};
        vecs[4] = '{start: 1'b0, abort: 1'b0, adc: 12'd200, exp_busy: 1'b0};
        vecs[5] = '{start: 1'b1, abort: 1'b0, adc: 12'd200, exp_busy: 1'b1};
        vecs[6] = '{start: 1'b0, abort: 1'b1, adc: 12'd0,   exp_busy: 1'b0};

        #3;
        check("rst_busy", busy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_done", frame_done, 0);
        check("rst_seq_error", seq_error, 0);
        check("rst_count_q", count_q, 0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        step();

        threshold = 12'd100;
        foreach (vecs[i]) begin
            start    = vecs[i].start;
            abort    = vecs[i].abort;
            adc_data = vecs[i].adc;
            step();
            check("vec_busy", busy, 32'(vecs[i].exp_busy));
            check("vec_count_enable", count_enable, 0);
            check("vec_wr_en", wr_en, 0);
        end
        start = 1'b0;
        abort = 1'b0;

        run_frame(12'd100, 2, 0, 64, 1'b0, 1'b0);
        finish_frame(1'b0);

        run_frame(12'd100, 3, 2, 64, 1'b0, 1'b0);
        finish_frame(1'b1);

        run_frame(12'd100, 1, 0, 20, 1'b0, 1'b0);

        run_frame(12'd200, 2, 0, 64, 1'b1, 1'b0);
        finish_frame(1'b0);

        run_frame(12'd50, 1, 0, 64, 1'b0, 1'b1);
        finish_frame(1'b0);
        run_frame(12'd50, 1, 1, 64, 1'b0, 1'b0);
        finish_frame(1'b0);

        // Reset pulse in the middle of a capture.
        threshold = 12'd100;
        start     = 1'b1;
        step();
        start    = 1'b0;
        adc_data = 12'd500;
        step();
        for (int i = 0; i < 30; i++) begin
            adc_data = DW'($urandom_range(1, 4095));
            step();
        end
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_peak_value", peak_value, 0);
        check("mid_rst_peak_index", peak_index, 0);
        check("mid_rst_count_q", count_q, 0);
        @(posedge clk);
        #3 resetn = 1'b1;
        step();
        run_frame(12'd100, 2, 0, 64, 1'b0, 1'b0);
        finish_frame(1'b0);

        for (int r = 0; r < 4; r++) begin
            run_frame(DW'($urandom_range(1, 4095)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 1)), 64, 1'b0, 1'b0);
            finish_frame(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
